// File: rtl/burst_memory_responder.sv
// Line-organised memory that answers each read/write request with four 64-bit beats.
// Optional protocol checker compiled in with BURST_MEM_PROTOCOL_CHECK_EN.
module burst_memory_responder #(
  parameter int unsigned ADDR_BITS = 5,
  parameter int unsigned LATENCY   = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        read_i,
  input  logic        write_i,
  input  logic [31:0] address_i,
  input  logic [63:0] burst_i,
  output logic [63:0] burst_o,
  output logic        resp_o,
  output logic        error_o
);

  localparam int unsigned Lines   = 2 ** ADDR_BITS;
  localparam logic [3:0]  LatInit = 4'(LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StWait, StBurst, StDone} state_e;

  state_e                 state_q, state_d;
  logic [3:0]             lat_q, lat_d;
  logic [1:0]             beat_q, beat_d;
  logic [1:0]             out_beat_q;
  logic                   is_write_q, is_write_d;
  logic [ADDR_BITS-1:0]   index_q, index_d;
  logic [ADDR_BITS-1:0]   req_index;
  logic                   resp_q;
  logic [63:0]            burst_q;
  logic [63:0]            mem_q [Lines][4];
  logic                   unused_addr;

  assign req_index   = address_i[ADDR_BITS+4:5];
  assign unused_addr = ^{address_i[31:ADDR_BITS+5], address_i[4:0]};

  always_comb begin
    state_d    = state_q;
    lat_d      = lat_q;
    beat_d     = beat_q;
    is_write_d = is_write_q;
    index_d    = index_q;
    unique case (state_q)
      StIdle: begin
        if (read_i || write_i) begin
          is_write_d = write_i;
          index_d    = req_index;
          beat_d     = 2'd0;
          lat_d      = LatInit;
          state_d    = (LATENCY <= 1) ? StBurst : StWait;
        end
      end
      StWait: begin
        lat_d = lat_q - 4'd1;
        if (lat_q <= 4'd1) begin
          lat_d   = 4'd0;
          state_d = StBurst;
        end
      end
      StBurst: begin
        beat_d = beat_q + 2'd1;
        if (beat_q == 2'd3) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // The output stage lags the fetch stage by one cycle, so resp_o/burst_o are pure flops.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      lat_q      <= 4'd0;
      beat_q     <= 2'd0;
      out_beat_q <= 2'd0;
      is_write_q <= 1'b0;
      index_q    <= '0;
      resp_q     <= 1'b0;
      burst_q    <= '0;
    end else begin
      state_q    <= state_d;
      lat_q      <= lat_d;
      beat_q     <= beat_d;
      out_beat_q <= beat_q;
      is_write_q <= is_write_d;
      index_q    <= index_d;
      resp_q     <= (state_q == StBurst);
      burst_q    <= (state_q == StBurst && !is_write_q) ? mem_q[index_q][beat_q] : '0;
    end
  end

  // Each write beat commits at the edge ending its resp_o cycle; reset blocks the commit.
  always_ff @(posedge clk) begin
    if (reset_n && resp_q && is_write_q) begin
      mem_q[index_q][out_beat_q] <= burst_i;
    end
  end

  assign resp_o  = resp_q;
  assign burst_o = burst_q;

`ifdef BURST_MEM_PROTOCOL_CHECK_EN
  logic error_q;
  logic active_req;
  logic in_txn;
  logic violation;

  always_comb begin
    active_req = is_write_q ? write_i : read_i;
    in_txn     = (state_q == StWait) || (state_q == StBurst);
    violation  = 1'b0;
    if (state_q == StIdle && read_i && write_i) violation = 1'b1;
    if (state_q == StIdle && (read_i || write_i) && address_i[4:0] != 5'd0) violation = 1'b1;
    if (in_txn && req_index != index_q) violation = 1'b1;
    // resp_q covers the beat-3 cycle, which is already in StDone.
    if ((in_txn || resp_q) && !active_req) violation = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      error_q <= 1'b0;
    end else if (violation) begin
      error_q <= 1'b1;
    end
  end

  assign error_o = error_q;
`else
  assign error_o = 1'b0;
`endif

endmodule

// File: tb/tb_burst_memory_responder.sv
// Scoreboard bench for burst_memory_responder: one instance at LATENCY=4, one at LATENCY=1.
module tb_burst_memory_responder;

  localparam int Lat0 = 4;
  localparam int Lat1 = 1;
`ifdef BURST_MEM_PROTOCOL_CHECK_EN
  localparam logic ExpErr = 1'b1;
`else
  localparam logic ExpErr = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        rd_r   [2];
  logic        wr_r   [2];
  logic [31:0] addr_r [2];
  logic [63:0] bin_r  [2];
  logic [63:0] bout   [2];
  logic        resp   [2];
  logic        err    [2];

  logic [63:0] model [2][32][4];
  logic [63:0] exp_q [2][$];
  logic        cur_read [2];
  logic        mon_en = 1'b0;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  burst_memory_responder #(.ADDR_BITS(5), .LATENCY(Lat0)) u_dut (
    .clk(clk), .reset_n(reset_n), .read_i(rd_r[0]), .write_i(wr_r[0]),
    .address_i(addr_r[0]), .burst_i(bin_r[0]), .burst_o(bout[0]), .resp_o(resp[0]),
    .error_o(err[0])
  );

  burst_memory_responder #(.ADDR_BITS(5), .LATENCY(Lat1)) u_dut_l1 (
    .clk(clk), .reset_n(reset_n), .read_i(rd_r[1]), .write_i(wr_r[1]),
    .address_i(addr_r[1]), .burst_i(bin_r[1]), .burst_o(bout[1]), .resp_o(resp[1]),
    .error_o(err[1])
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Read beats are checked against the scoreboard; otherwise burst_o must be zero.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int k = 0; k < 2; k++) begin
        if (resp[k] && cur_read[k]) begin
          if (exp_q[k].size() > 0) check_eq("rd_beat", bout[k], exp_q[k].pop_front());
          else check_eq("rd_beat_extra", bout[k], 64'hBAD0_BAD0_BAD0_BAD0);
        end else begin
          check_eq("burst_idle", bout[k], 64'h0);
        end
      end
    end
  end

  function automatic int lat_of(input int k);
    return (k == 0) ? Lat0 : Lat1;
  endfunction

  task automatic run_txn(input int k, input bit wr, input bit both, input logic [31:0] addr,
                         input logic [63:0] d0, input logic [63:0] d1, input logic [63:0] d2,
                         input logic [63:0] d3, input int abort_at, input bit hold,
                         output int acc);
    logic [63:0] beats [4];
    int idx;
    int lat;
    int j;
    beats = '{d0, d1, d2, d3};
    idx   = int'(addr[9:5]);
    lat   = lat_of(k);
    @(negedge clk);
    addr_r[k]   = addr;
    wr_r[k]     = wr;
    rd_r[k]     = !wr || both;
    cur_read[k] = !wr;
    if (!wr) for (int b = 0; b < 4; b++) exp_q[k].push_back(model[k][idx][b]);
    @(posedge clk); #1;
    acc = cyc;
    for (int i = 1; i <= lat + 3; i++) begin
      @(posedge clk); #1;
      check_eq("resp_timing", 64'(resp[k]), 64'(i >= lat));
      if (wr && i >= lat) begin
        j = i - lat;
        if (j == abort_at) begin
          reset_n = 1'b0;
          wr_r[k] = 1'b0;
          rd_r[k] = 1'b0;
          for (int r = 0; r < 2; r++) begin
            @(posedge clk); #1;
            check_eq("rst_resp", 64'(resp[k]), 64'h0);
            check_eq("rst_burst", bout[k], 64'h0);
          end
          reset_n = 1'b1;
          return;
        end
        bin_r[k]        = beats[j];
        model[k][idx][j] = beats[j];
      end
    end
    @(posedge clk); #1;
    check_eq("resp_done_low", 64'(resp[k]), 64'h0);
    if (!hold) begin
      rd_r[k] = 1'b0;
      wr_r[k] = 1'b0;
    end
  endtask

  int a0, a1;
  localparam logic [63:0] Z = 64'h0;

  initial begin
    for (int k = 0; k < 2; k++) begin
      rd_r[k] = 1'b0; wr_r[k] = 1'b0; addr_r[k] = '0; bin_r[k] = '0; cur_read[k] = 1'b0;
      for (int l = 0; l < 32; l++) for (int b = 0; b < 4; b++) model[k][l][b] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      check_eq("reset_resp", 64'(resp[k]), 64'h0);
      check_eq("reset_burst", bout[k], 64'h0);
      check_eq("reset_err", 64'(err[k]), 64'h0);
    end
    reset_n = 1'b1;
    mon_en  = 1'b1;

    // Write then read a line.
    run_txn(0, 1, 0, 32'h40, 64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
            64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444, -1, 0, a0);
    run_txn(0, 0, 0, 32'h40, Z, Z, Z, Z, -1, 0, a0);
    // Never-written line reads as zero.
    run_txn(0, 0, 0, 32'h80, Z, Z, Z, Z, -1, 0, a0);
    // Back-to-back reads with the request held.
    run_txn(0, 0, 0, 32'h40, Z, Z, Z, Z, -1, 1, a0);
    run_txn(0, 0, 0, 32'h40, Z, Z, Z, Z, -1, 0, a1);
    check_eq("b2b_gap", 64'(a1 - a0), 64'(Lat0 + 5));
    check_eq("err_clean", 64'(err[0]), 64'h0);

    // Write interrupted by reset after beat 1 keeps beats 0-1 only.
    run_txn(0, 1, 0, 32'h20, 64'h0101_0101_0101_0101, 64'h0202_0202_0202_0202,
            64'h0303_0303_0303_0303, 64'h0404_0404_0404_0404, -1, 0, a0);
    run_txn(0, 1, 0, 32'h20, {4{16'hAAAA}}, {4{16'hAAAA}}, {4{16'hAAAA}}, {4{16'hAAAA}},
            2, 0, a0);
    run_txn(0, 0, 0, 32'h20, Z, Z, Z, Z, -1, 0, a0);

    // LATENCY=1 instance: upper address bits alias.
    run_txn(1, 1, 0, 32'h420, 64'hDEAD_BEEF_0000_0001, 64'hDEAD_BEEF_0000_0002,
            64'hDEAD_BEEF_0000_0003, 64'hDEAD_BEEF_0000_0004, -1, 0, a0);
    run_txn(1, 0, 0, 32'h20, Z, Z, Z, Z, -1, 0, a0);
    check_eq("l1_err_clean", 64'(err[1]), 64'h0);

    // Simultaneous read and write: the write wins.
    run_txn(0, 1, 1, 32'h60, 64'h5A5A_0000_0000_0001, 64'h5A5A_0000_0000_0002,
            64'h5A5A_0000_0000_0003, 64'h5A5A_0000_0000_0004, -1, 0, a0);
    check_eq("err_both", 64'(err[0]), 64'(ExpErr));
    run_txn(0, 0, 0, 32'h60, Z, Z, Z, Z, -1, 0, a0);
    check_eq("err_sticky", 64'(err[0]), 64'(ExpErr));
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk); #1;
    check_eq("err_cleared", 64'(err[0]), 64'h0);
    reset_n = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) check_eq("sb_empty", 64'(exp_q[k].size()), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
